// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore control unit for the multicycle MIPS-subset datapath. It sequences
// fetch, decode, execute, memory and write-back, and drives every datapath
// control input from the current state. The opcode/func fields are read
// from the datapath's IR. The only Mealy output is PCLoad in BRANCH, which
// follows the ALU zero flag.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset; forces all outputs to 0
//   opc          in   IR[31:26]
//   func         in   IR[5:0]
//   zero         in   ALU zero flag (current cycle)
//   PCLoad       out  PC load enable
//   IorD         out  memory address select (0 PC, 1 ALUOut)
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  IR load enable
//   RegDst       out  write register select (0 rt, 1 rd)
//   JalSig1      out  force write register to r31
//   MemToReg     out  write data select (0 ALUOut, 1 MDR)
//   JalSig2      out  force write data to PC
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A select (0 PC, 1 A)
//   ALUSrcB      out  ALU B select (00 B, 01 4, 10 SE(imm), 11 SE(imm)<<2)
//   ALUOperation out  ALU op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//   PCSrc        out  PC source (00 ALU, 01 jump, 10 ALUOut, 11 A)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_REXEC    = 4'd6;
  localparam logic [3:0] S_RWB      = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_IEXEC    = 4'd9;
  localparam logic [3:0] S_IWB      = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] nextState;
  logic [2:0] rTypeOp;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nextState;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH:  nextState = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW:    nextState = S_MEMADR;
          OP_RTYPE:        nextState = (func == FN_JR) ? S_JR : S_REXEC;
          OP_BEQ, OP_BNE:  nextState = S_BRANCH;
          OP_ADDI, OP_SLTI: nextState = S_IEXEC;
          OP_J:            nextState = S_JUMP;
          OP_JAL:          nextState = S_JAL;
          default:         nextState = S_FETCH;  // unsupported opcode: NOP
        endcase
      end
      S_MEMADR:  nextState = (opc == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: nextState = S_MEMWB;
      S_REXEC:   nextState = S_RWB;
      S_IEXEC:   nextState = S_IWB;
      default:   nextState = S_FETCH;
    endcase
  end

  // Unknown func codes fall back to ADD and still write back.
  always_comb begin
    rTypeOp = ALU_ADD;
    case (func)
      FN_ADD:  rTypeOp = ALU_ADD;
      FN_SUB:  rTypeOp = ALU_SUB;
      FN_AND:  rTypeOp = ALU_AND;
      FN_OR:   rTypeOp = ALU_OR;
      FN_SLT:  rTypeOp = ALU_SLT;
      default: rTypeOp = ALU_ADD;
    endcase
  end

  always_comb begin
    PCLoad       = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    JalSig1      = 1'b0;
    MemToReg     = 1'b0;
    JalSig2      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_AND;
    PCSrc        = 2'b00;
    // Outputs are gated by rst so no write can slip out during reset.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRead      = 1'b1;
          IRWrite      = 1'b1;
          PCLoad       = 1'b1;
          ALUSrcB      = 2'b01;
          ALUOperation = ALU_ADD;
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          ALUSrcB      = 2'b11;
          ALUOperation = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUOperation = ALU_ADD;
        end
        S_MEMREAD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_REXEC: begin
          ALUSrcA      = 1'b1;
          ALUOperation = rTypeOp;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUOperation = ALU_SUB;
          PCSrc        = 2'b10;
          PCLoad       = (opc == OP_BNE) ? ~zero : zero;
        end
        S_IEXEC: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUOperation = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_IWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc  = 2'b01;
          PCLoad = 1'b1;
        end
        S_JAL: begin
          // PC already holds PC+4 from FETCH; that value goes to r31.
          PCSrc    = 2'b01;
          PCLoad   = 1'b1;
          JalSig1  = 1'b1;
          JalSig2  = 1'b1;
          RegWrite = 1'b1;
        end
        S_JR: begin
          PCSrc  = 2'b11;
          PCLoad = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
